// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-memory / IO block: IO register offsets,
// the address bit that selects IO space, and the UART serializer states.
package data_mem_io_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [1:0] IO_LEDS        = 2'd0;
    localparam logic [1:0] IO_UART_DATA   = 2'd1;
    localparam logic [1:0] IO_UART_STATUS = 2'd2;
    localparam logic [1:0] IO_CYCLES      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_serializer
    import data_mem_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_byte,
    input  logic       i_clr_ovf,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr, r_rd_ptr;
    logic          r_ovf;
    uart_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    w_head;
    logic          w_empty, w_full, w_pop, w_push_ok, w_baud_done;

    // Extra MSB on the pointers tells full from empty when indices match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                         (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push_ok   = i_push && (!w_full || w_pop);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_head      = r_fifo[r_rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr[PW-1:0]] <= i_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_push_ok)
                r_ovf <= 1'b1;
            else if (i_clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7)
                        w_state_nxt = ST_STOP;
                    else
                        w_bit_nxt = r_bit + 1'b1;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame, no idle bit.
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            ST_START: o_tx = 1'b0;
            ST_DATA:  o_tx = r_shift[0];
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_full     = w_full;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/data_mem_io.sv
// Core M-stage data memory plus memory-mapped IO (LEDs, UART TX, cycle count).
// Define DATA_MEM_IO_CYCLE_COUNTER_EN to build the free-running CYCLES counter.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   r_ram [MEM_WORDS];
    logic [7:0]    r_leds;
    logic [AW-1:0] w_ram_idx;
    logic [1:0]    w_io_off;
    logic [31:0]   w_cycles;
    logic          w_io_sel, w_ram_we, w_io_we, w_push, w_clr_ovf;
    logic          w_full, w_busy, w_ovf;
    logic          w_unused;

    assign w_ram_idx = Address[AW+1:2];
    assign w_io_sel  = Address[IO_SEL_BIT];
    assign w_io_off  = Address[3:2];
    assign w_ram_we  = MemWrite && !w_io_sel;
    assign w_io_we   = MemWrite && w_io_sel;
    assign w_push    = w_io_we && (w_io_off == IO_UART_DATA);
    assign w_clr_ovf = w_io_we && (w_io_off == IO_UART_STATUS) && WriteData[2];
    assign w_unused  = ^{Address, WriteData};

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[w_ram_idx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_leds <= '0;
        else if (w_io_we && (w_io_off == IO_LEDS))
            r_leds <= WriteData[7:0];
    end

`ifdef DATA_MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (reset)
            r_cycles <= '0;
        else
            r_cycles <= r_cycles + 32'd1;
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_push     (w_push),
        .i_byte     (WriteData[7:0]),
        .i_clr_ovf  (w_clr_ovf),
        .o_full     (w_full),
        .o_busy     (w_busy),
        .o_overflow (w_ovf),
        .o_tx       (uart_tx)
    );

    // Zero-latency read: the core samples ReadData in the address cycle.
    always_comb begin
        ReadData = '0;
        if (!w_io_sel) begin
            ReadData = r_ram[w_ram_idx];
        end else begin
            case (w_io_off)
                IO_LEDS:        ReadData = {24'd0, r_leds};
                IO_UART_STATUS: ReadData = {29'd0, w_ovf, w_busy, w_full};
                IO_CYCLES:      ReadData = w_cycles;
                default:        ReadData = '0;
            endcase
        end
    end

    assign leds = r_leds;

endmodule

// File: tb/tb_data_mem_io.sv
// Randomized + directed bench for data_mem_io against a queue-based model.
module tb_data_mem_io;

    localparam int MEM_WORDS = 1024;
    localparam int CPB       = 16;
    localparam int FD        = 8;
    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_UDATA  = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_CYCLES = 32'h0040_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        uart_tx;

    data_mem_io #(
        .MEM_WORDS    (MEM_WORDS),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: RAM as a sparse array, FIFO as a byte queue, and the
    // serial line as a queue of per-cycle levels still to be driven.
    logic [31:0]  m_ram [int];
    logic [7:0]   m_leds;
    byte unsigned m_fifo [$];
    bit           m_line [$];
    bit           m_ovf;
    logic [31:0]  m_cycles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    function automatic bit m_known(input logic [31:0] a);
        if (a[22]) return 1'b1;
        return m_ram.exists(m_idx(a));
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (!a[22]) return m_ram[m_idx(a)];
        case (a[3:2])
            2'd0: return {24'd0, m_leds};
            2'd2: return {29'd0, m_ovf, m_line.size() != 0, m_fifo.size() == FD};
`ifdef DATA_MEM_IO_CYCLE_COUNTER_EN
            2'd3: return m_cycles;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_frame(input byte unsigned b);
        for (int i = 0; i < CPB; i++) m_line.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CPB; i++) m_line.push_back(b[k]);
        for (int i = 0; i < CPB; i++) m_line.push_back(1'b1);
    endfunction

    task automatic m_step();
        bit pop;
        if (reset) begin
            m_leds = 8'd0;
            m_fifo.delete();
            m_line.delete();
            m_ovf = 1'b0;
            m_cycles = 32'd0;
        end else begin
            pop = (m_fifo.size() != 0) && (m_line.size() <= 1);
            m_cycles = m_cycles + 32'd1;
            if (m_line.size() != 0) void'(m_line.pop_front());
            if (pop) m_frame(m_fifo.pop_front());
            if (MemWrite) begin
                if (!Address[22]) m_ram[m_idx(Address)] = WriteData;
                else case (Address[3:2])
                    2'd0: m_leds = WriteData[7:0];
                    2'd1: if (m_fifo.size() < FD) m_fifo.push_back(WriteData[7:0]);
                          else m_ovf = 1'b1;
                    2'd2: if (WriteData[2]) m_ovf = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        chk("tx", {31'd0, uart_tx}, (m_line.size() != 0) ? {31'd0, m_line[0]} : 32'd1);
        chk("leds", {24'd0, leds}, {24'd0, m_leds});
        if (m_known(Address)) chk("rdata", ReadData, m_rd(Address));
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        Address = a;
        MemWrite = 1'b0;
        #1;
        if (m_known(a)) chk(tag, ReadData, m_rd(a));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        WriteData = d;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        MemWrite = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    logic [31:0] ram_addrs [$];
    logic [7:0]  d5a = 8'h5A;
    logic [31:0] a;
    int          lvl;

    initial begin
        // Reset state
        Address = A_STATUS;
        do_reset(2);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        rd(A_STATUS, "rst_status");
        chk("rst_status_c", ReadData, 32'd0);

        // Cycle counter 100 cycles after reset
        Address = A_CYCLES;
        repeat (100) tick();
        rd(A_CYCLES, "cycles");
`ifdef DATA_MEM_IO_CYCLE_COUNTER_EN
        chk("cycles_c", ReadData, 32'd100);
`else
        chk("cycles_c", ReadData, 32'd0);
`endif

        // RAM write, wrap-around read, read-during-write returns old data
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, "ram_rd");
        chk("ram_rd_c", ReadData, 32'hDEAD_BEEF);
        rd(32'h0000_1010, "ram_wrap");
        chk("ram_wrap_c", ReadData, 32'hDEAD_BEEF);
        Address = 32'h0000_0010;
        WriteData = 32'h1234_5678;
        MemWrite = 1'b1;
        #1;
        chk("ram_rdw_old", ReadData, 32'hDEAD_BEEF);
        tick();
        MemWrite = 1'b0;
        rd(32'h0000_1013, "ram_rdw_new");
        chk("ram_rdw_new_c", ReadData, 32'h1234_5678);

        // LEDs, ignored CYCLES write, write-only UART_DATA reads 0
        wr(A_LEDS, 32'hFFFF_A5C3);
        rd(A_LEDS, "leds_rd");
        chk("leds_rd_c", ReadData, 32'h0000_00C3);
        wr(A_CYCLES, 32'hFFFF_FFFF);
        rd(A_UDATA, "udata_rd");
        chk("udata_rd_c", ReadData, 32'd0);

        // 0x5A frame: start, LSB-first data, stop, busy throughout
        wr(A_UDATA, 32'h0000_005A);
        Address = A_STATUS;
        tick();
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k < CPB) lvl = 0;
            else if (k < 9 * CPB) lvl = int'(d5a[(k - CPB) / CPB]);
            else lvl = 1;
            chk("frame_bit", {31'd0, uart_tx}, 32'(lvl));
            chk("frame_busy", {31'd0, ReadData[1]}, 32'd1);
            tick();
        end
        chk("frame_idle", {31'd0, ReadData[1]}, 32'd0);

        // Overflow: one frame in flight, then 9 pushes into an 8-deep FIFO
        do_reset(1);
        wr(A_UDATA, 32'h11);
        repeat (3) tick();
        for (int i = 0; i < 9; i++) wr(A_UDATA, 32'h20 + 32'(i));
        rd(A_STATUS, "ovf_status");
        chk("ovf_status_c", ReadData, 32'h7);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, "ovf_clr");
        chk("ovf_clr_c", ReadData, 32'h3);

        // Reset during DATA bit 3 of 0x96 (bit 3 is 0, so line is low)
        do_reset(1);
        wr(A_LEDS, 32'hFF);
        wr(A_UDATA, 32'h96);
        tick();
        repeat (CPB + 3 * CPB + 5) tick();
        chk("mid_bit3", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_leds", {24'd0, leds}, 32'd0);
        rd(A_STATUS, "mid_rst_status");
        chk("mid_rst_status_c", ReadData, 32'd0);
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: begin
                    a = $urandom;
                    a[22] = 1'b0;
                    ram_addrs.push_back(a);
                    wr(a, $urandom);
                end
                1: if (ram_addrs.size() != 0) begin
                    a = ram_addrs[$urandom_range(0, ram_addrs.size() - 1)];
                    a = a ^ (32'($urandom_range(0, 3)) << 12);
                    rd(a, "rnd_ram");
                    tick();
                end
                2: wr(A_LEDS, $urandom);
                3, 4: wr(A_UDATA, $urandom);
                5: begin rd(A_STATUS, "rnd_status"); tick(); end
                6: wr(A_STATUS, $urandom);
                default: repeat ($urandom_range(1, 40)) tick();
            endcase
        end
        rd(A_CYCLES, "rnd_cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
- REQ-001 SHALL have parameter MEM_WORDS, default 1024: data RAM depth in 32-bit words (power of two).
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit.
- REQ-003 SHALL have parameter FIFO_DEPTH, default 8: UART TX FIFO entries (power of two).
- REQ-004 SHALL have ports:
  - clk  in  1  clock.
  - reset  in  1  synchronous, active-high.
  - Address  in  32  byte address from the core M stage.
  - WriteData  in  32  store data.
  - MemWrite  in  1  store strobe, whole-word.
  - ReadData  out  32  load data.
  - leds  out  8  LED register.
  - uart_tx  out  1  serial line, idle high.

Function
- REQ-005 Address[22]=0 SHALL select RAM, indexed by Address[31:2] modulo MEM_WORDS (wrap-around); Address[1:0] ignored.
- REQ-006 Address[22]=1 SHALL select IO, decoded by Address[3:2]:
  - 0 LEDS (R/W, bits 7:0).
  - 1 UART_DATA (W: push byte WriteData[7:0]; R: 0).
  - 2 UART_STATUS: bit0 full, bit1 busy, bit2 overflow (sticky); write with bit2=1 clears overflow.
  - 3 CYCLES (R, see REQ-016).
- REQ-007 ReadData SHALL be combinational from Address (zero-latency), because the core samples it in the same cycle it presents Address.
- REQ-008 A RAM write SHALL take effect at the rising edge; a read of the same word in the write cycle SHALL return the old value.
- REQ-009 Writes to CYCLES and reads of unused IO bits SHALL be ignored and read as 0.
- REQ-010 A push while the FIFO is full SHALL drop the byte and set overflow, except when a pop occurs in the same cycle; in that case the push SHALL be accepted.
- REQ-011 UART FSM states SHALL be IDLE, START, DATA, STOP:
  - IDLE to START when the FIFO is non-empty; pop on that transition.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP drives 1 for CLKS_PER_BIT cycles, then goes to IDLE, or directly to START with a pop if the FIFO is non-empty (back-to-back frames, no idle gap).
- REQ-012 busy SHALL be 1 in every state except IDLE.
- REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished with an extra pointer bit.

Reset
- REQ-014 On reset the block SHALL set:
  - leds=0, uart_tx=1, FSM=IDLE, FIFO empty.
  - overflow=0, baud and bit counters=0, CYCLES=0.
- REQ-015 Reset mid-frame SHALL abort the frame; uart_tx SHALL be 1 after the first reset edge. RAM contents are not reset.

Configuration
- REQ-016 With DATA_MEM_IO_CYCLE_COUNTER_EN defined, CYCLES SHALL be a 32-bit counter incrementing every non-reset cycle and wrapping 0xFFFFFFFF to 0. Without it, CYCLES SHALL read 0 and no counter flops SHALL exist.

Structure
- REQ-017 Package data_mem_io_pkg SHALL hold:
  - the IO offset constants (LEDS, UART_DATA, UART_STATUS, CYCLES);
  - the IO-select bit index 22;
  - the UART state enum.
- REQ-018 The FIFO and FSM SHALL live in sub-module uart_tx_serializer (push, byte, full, busy, tx); RAM and decode stay in the top.

Verification
- REQ-019 The bench SHALL cover:
  - Write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00001010 (wraps with MEM_WORDS=1024) -> both return 0xDEADBEEF.
  - Write 0x5A to UART_DATA (0x00400004) -> uart_tx low 16 cycles, bits 0,1,0,1,1,0,1,0, then high 16 cycles; busy=1 throughout.
  - Push 9 bytes with no intervening frame start -> 9th dropped, STATUS reads 0x7 (full|busy|overflow after first pop); write STATUS 0x4 -> overflow=0.
  - Reset asserted during DATA bit 3 -> uart_tx=1, STATUS=0, leds=0 next cycle.
  - With macro, 100 cycles after reset, read CYCLES -> 100; without macro -> 0.
